voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
Schedules note events onto the synth's voice pool. It accepts note-on/note-off events over a valid/ready handshake and picks a voice: a voice already holding the note, else a free voice, else the oldest busy voice (stolen). It then sequences single-cycle writes on the synth register-write bus (number/value/write-enable). It sits between the host/MIDI front end and the synth register port, and is the only writer of voice Frequency and KeyOn registers.

Parameters:
NUM_VOICES, 2, voices managed (1..16); voice v (0-based) register base = v*8'h10
AGE_W, 4, width of per-voice age counters (saturating)
OP2_SHIFT, 0, operator 2 frequency = i_Frequency << OP2_SHIFT (truncated to 24 bits)

Ports:
i_Clock  in  1  clock
i_Reset  in  1  synchronous, active-high reset
i_NoteValid  in  1  note event valid
o_NoteReady  out  1  event accepted when valid & ready
i_NoteOn  in  1  1 = note-on, 0 = note-off
i_NoteId  in  7  note identifier (MIDI number)
i_Frequency  in  24  phase-increment word (note-on only)
o_RegisterNumber  out  8  register address
o_RegisterValue  out  24  register data
o_RegisterWriteEnable  out  1  one-cycle write strobe
o_Dropped  out  1  one-cycle pulse: note-on discarded (no voice)
o_ActiveVoices  out  NUM_VOICES  busy flag per voice

Behaviour:
- Reset: FSM IDLE; all voices free, ages 0, note ids 0; o_NoteReady=1 on the cycle after reset deasserts; o_RegisterWriteEnable=0, o_RegisterNumber=0, o_RegisterValue=0, o_Dropped=0, o_ActiveVoices=0. Reset mid-sequence aborts it with no further writes; the synth resets KeyOn itself.
- Register offsets within a voice: 8'h02 Op1 Frequency, 8'h04 Op2 Frequency, 8'h05 KeyOn (value 24'h1 on, 24'h0 off). Amplitude and Algorithm are never written.
- States: IDLE -> SEARCH -> {WR_KEYOFF, WR_FREQ1, WR_FREQ2, WR_KEYON} -> IDLE. o_NoteReady=1 only in IDLE. The event is latched on accept (cycle T).
- SEARCH (T+1), registered decision:
  - Note-on: first match (busy & id==i_NoteId, lowest index) = retrigger; else lowest-index free voice = fresh; else oldest busy voice (max age, ties to lowest index) = steal.
  - Note-off: lowest-index busy voice with matching id, else no match.
- Note-on fresh: WR_FREQ1 at T+2, WR_FREQ2 at T+3, WR_KEYON at T+4; ready at T+5.
- Note-on retrigger or steal: WR_KEYOFF at T+2, then the frequency and KeyOn writes at T+3..T+5; ready at T+6.
- Note-off match: WR_KEYOFF at T+2, voice freed in the same cycle; ready at T+3. No match: no writes, ready at T+2.
- Exactly one write per cycle in WR_* states. Outputs are registered. o_RegisterNumber/Value hold their last value when the strobe is low.
- Voice state update happens at WR_KEYON: busy=1, id stored, age=0. All other busy voices' ages increment, saturating at 2^AGE_W-1.
- o_ActiveVoices reflects busy flags registered; updates the cycle after WR_KEYON or WR_KEYOFF (note-off).
- A note-off while the same note's note-on is still sequencing is not possible, because events are serialized by the handshake.

Optional Feature:
VOICE_ALLOC_STEAL_EN
- Defined: when all voices are busy and there is no id match, the oldest voice is stolen as above; o_Dropped is never asserted.
- Undefined: that note-on produces no writes; o_Dropped pulses 1 cycle at T+2; ready at T+2; voice state is unchanged.

Test Plan:
- Reset then note-on id 60, freq 24'h001000 (NUM_VOICES=2) -> writes (8'h02,24'h001000)@T+2, (8'h04,24'h001000)@T+3, (8'h05,1)@T+4; o_ActiveVoices=2'b01.
- Note-on id 64, freq 24'h001400 -> writes to 8'h12, 8'h14, 8'h15; o_ActiveVoices=2'b11.
- Third note-on id 67, freq 24'h001800, STEAL_EN defined -> (8'h05,0), then 8'h02/8'h04=24'h001800, then (8'h05,1): voice 0 was oldest. Same case with STEAL_EN undefined -> no write strobe, o_Dropped pulse at T+2.
- Note-off id 64 -> single write (8'h15,0) at T+2, o_ActiveVoices bit1 clears. Note-off id 99 (unmatched) -> no write, ready at T+2.
- Retrigger note-on id 60 with freq 24'h002000 while busy -> KEYOFF/FREQ/KEYON on voice 0 only, voice 1 untouched.
- Assert i_Reset at the WR_FREQ2 cycle -> no further strobes, o_ActiveVoices=0, ready the cycle after reset deasserts. OP2_SHIFT=1: freq 24'h001000 -> 8'h04 value 24'h002000.

Source files
------------

// File: rtl/voice_allocator.sv
// voice_allocator: maps note-on/note-off events onto a pool of synth voices.
// It takes one event at a time over a valid/ready handshake. For each event it
// picks a voice in this order: a retrigger of a voice already holding the note,
// then a fresh free voice, then a steal of the oldest voice. It then issues
// single-cycle writes on the synth register bus (number/value/write-enable).
//
// Build option: define VOICE_ALLOC_STEAL_EN so that a note-on arriving when
// every voice is busy steals the oldest voice. Without it, that note-on is
// dropped and o_Dropped pulses for one cycle.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | ready for an event; the event is latched on accept
// S_SEARCH   | pick a voice from the voice table; the choice is registered
// S_WR_KEYOFF| write KeyOn=0 (retrigger, steal, or note-off)
// S_WR_FREQ1 | write the Op1 frequency
// S_WR_FREQ2 | write the Op2 frequency (shifted by OP2_SHIFT)
// S_WR_KEYON | write KeyOn=1 and update the voice table

module voice_allocator #(
    parameter int NUM_VOICES = 2,
    parameter int AGE_W      = 4,
    parameter int OP2_SHIFT  = 0
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_NoteValid,
    output logic                  o_NoteReady,
    input  logic                  i_NoteOn,
    input  logic [6:0]            i_NoteId,
    input  logic [23:0]           i_Frequency,
    output logic [7:0]            o_RegisterNumber,
    output logic [23:0]           o_RegisterValue,
    output logic                  o_RegisterWriteEnable,
    output logic                  o_Dropped,
    output logic [NUM_VOICES-1:0] o_ActiveVoices
);

    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    localparam logic [3:0] OFS_FREQ1 = 4'h2;
    localparam logic [3:0] OFS_FREQ2 = 4'h4;
    localparam logic [3:0] OFS_KEYON = 4'h5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEARCH,
        S_WR_KEYOFF,
        S_WR_FREQ1,
        S_WR_FREQ2,
        S_WR_KEYON
    } state_t;

    typedef enum logic [1:0] {
        D_NONE,   // no voice: dropped note-on, or note-off with no matching voice
        D_FRESH,  // free voice, so no key-off is needed first
        D_KILL    // voice is sounding: key-off first (retrigger, steal, note-off)
    } decision_t;

    state_t state_q, state_d;

    // latched event
    logic        ev_on_q;
    logic [6:0]  ev_id_q;
    logic [23:0] ev_freq_q;
    logic [23:0] freq_op2;

    // voice table
    logic [NUM_VOICES-1:0] busy_q;
    logic [6:0]            id_q  [NUM_VOICES];
    logic [AGE_W-1:0]      age_q [NUM_VOICES];

    // voice search
    logic            match_found, free_found;
    logic [VW-1:0]   match_idx, free_idx, old_idx;
    logic [AGE_W-1:0] old_age;
    decision_t       dec_kind;
    logic [VW-1:0]   dec_idx;
    logic [VW-1:0]   sel_q, sel_d;

    // registered outputs
    logic [7:0]  reg_num_q, reg_num_d;
    logic [23:0] reg_val_q, reg_val_d;
    logic        reg_we_q, reg_we_d;
    logic        dropped_q, dropped_d;

    logic        accept;

    assign o_NoteReady           = (state_q == S_IDLE);
    assign accept                = i_NoteValid && o_NoteReady;
    assign freq_op2              = ev_freq_q << OP2_SHIFT;
    assign o_RegisterNumber      = reg_num_q;
    assign o_RegisterValue       = reg_val_q;
    assign o_RegisterWriteEnable = reg_we_q;
    assign o_Dropped             = dropped_q;
    assign o_ActiveVoices        = busy_q;

    // State register
    always_ff @(posedge i_Clock) begin
        if (i_Reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Latch the event on accept; lock in the chosen voice when leaving SEARCH
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            ev_on_q   <= 1'b0;
            ev_id_q   <= '0;
            ev_freq_q <= '0;
            sel_q     <= '0;
        end else begin
            if (accept) begin
                ev_on_q   <= i_NoteOn;
                ev_id_q   <= i_NoteId;
                ev_freq_q <= i_Frequency;
            end
            sel_q <= sel_d;
        end
    end

    // Scan the voice table for a matching id, the first free voice, and the oldest voice
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        old_idx     = '0;
        old_age     = age_q[0];
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!match_found && busy_q[v] && (id_q[v] == ev_id_q)) begin
                match_found = 1'b1;
                match_idx   = VW'(v);
            end
            if (!free_found && !busy_q[v]) begin
                free_found = 1'b1;
                free_idx   = VW'(v);
            end
        end
        // strict '>' keeps ties on the lowest index
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (age_q[v] > old_age) begin
                old_age = age_q[v];
                old_idx = VW'(v);
            end
        end
    end

    // Decide between retrigger, fresh, steal/drop (note-on) and match/none (note-off)
    always_comb begin
        dec_kind = D_NONE;
        dec_idx  = old_idx;
        if (ev_on_q) begin
            if (match_found) begin
                dec_kind = D_KILL;
                dec_idx  = match_idx;
            end else if (free_found) begin
                dec_kind = D_FRESH;
                dec_idx  = free_idx;
            end else begin
`ifdef VOICE_ALLOC_STEAL_EN
                dec_kind = D_KILL;
`else
                dec_kind = D_NONE;
`endif
            end
        end else if (match_found) begin
            dec_kind = D_KILL;
            dec_idx  = match_idx;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_SEARCH;
            end
            S_SEARCH: begin
                sel_d = dec_idx;
                case (dec_kind)
                    D_FRESH: state_d = S_WR_FREQ1;
                    D_KILL:  state_d = S_WR_KEYOFF;
                    default: state_d = S_IDLE;
                endcase
            end
            S_WR_KEYOFF: state_d = ev_on_q ? S_WR_FREQ1 : S_IDLE;
            S_WR_FREQ1:  state_d = S_WR_FREQ2;
            S_WR_FREQ2:  state_d = S_WR_KEYON;
            S_WR_KEYON:  state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Output logic: build the bus write for the state being entered so the outputs can be registered
    always_comb begin
        reg_we_d  = 1'b0;
        reg_num_d = reg_num_q;
        reg_val_d = reg_val_q;
        dropped_d = (state_q == S_SEARCH) && ev_on_q && (dec_kind == D_NONE);
        case (state_d)
            S_WR_KEYOFF: begin
                reg_we_d  = 1'b1;
                reg_num_d = {4'(sel_d), OFS_KEYON};
                reg_val_d = 24'h0;
            end
            S_WR_FREQ1: begin
                reg_we_d  = 1'b1;
                reg_num_d = {4'(sel_d), OFS_FREQ1};
                reg_val_d = ev_freq_q;
            end
            S_WR_FREQ2: begin
                reg_we_d  = 1'b1;
                reg_num_d = {4'(sel_d), OFS_FREQ2};
                reg_val_d = freq_op2;
            end
            S_WR_KEYON: begin
                reg_we_d  = 1'b1;
                reg_num_d = {4'(sel_d), OFS_KEYON};
                reg_val_d = 24'h1;
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            reg_we_q  <= 1'b0;
            reg_num_q <= '0;
            reg_val_q <= '0;
            dropped_q <= 1'b0;
        end else begin
            reg_we_q  <= reg_we_d;
            reg_num_q <= reg_num_d;
            reg_val_q <= reg_val_d;
            dropped_q <= dropped_d;
        end
    end

    // Voice table: claim the voice at key-on and age the others; free the voice on note-off key-off
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            busy_q <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                id_q[v]  <= '0;
                age_q[v] <= '0;
            end
        end else if (state_q == S_WR_KEYON) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (VW'(v) == sel_q) begin
                    busy_q[v] <= 1'b1;
                    id_q[v]   <= ev_id_q;
                    age_q[v]  <= '0;
                end else if (busy_q[v] && (age_q[v] != AGE_MAX)) begin
                    age_q[v]  <= age_q[v] + 1'b1;
                end
            end
        end else if ((state_q == S_WR_KEYOFF) && !ev_on_q) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (VW'(v) == sel_q) busy_q[v] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: the stimulus pushes the expected bus
// writes and drop pulses with their absolute cycle numbers, and monitors pop
// and compare them whenever a DUT strobes. A second instance checks OP2_SHIFT=1.
module tb_voice_allocator;

    typedef struct {
        bit          is_drop;
        logic [7:0]  num;
        logic [23:0] val;
        int          cyc;
    } exp_t;

`ifdef VOICE_ALLOC_STEAL_EN
    localparam logic [6:0] V0_ID = 7'd67;
`else
    localparam logic [6:0] V0_ID = 7'd60;
`endif

    logic        i_Clock = 1'b0;
    logic        i_Reset = 1'b1;

    logic        i_NoteValid, o_NoteReady, i_NoteOn;
    logic [6:0]  i_NoteId;
    logic [23:0] i_Frequency;
    logic [7:0]  o_RegisterNumber;
    logic [23:0] o_RegisterValue;
    logic        o_RegisterWriteEnable, o_Dropped;
    logic [1:0]  o_ActiveVoices;

    logic        i2_NoteValid, o2_NoteReady, i2_NoteOn;
    logic [6:0]  i2_NoteId;
    logic [23:0] i2_Frequency;
    logic [7:0]  o2_RegisterNumber;
    logic [23:0] o2_RegisterValue;
    logic        o2_RegisterWriteEnable, o2_Dropped;
    logic [1:0]  o2_ActiveVoices;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   t1, t2;
    exp_t q1[$];
    exp_t q2[$];
    exp_t m1, m2;

    voice_allocator #(.NUM_VOICES(2), .AGE_W(4), .OP2_SHIFT(0)) u_dut (
        .i_Clock(i_Clock), .i_Reset(i_Reset),
        .i_NoteValid(i_NoteValid), .o_NoteReady(o_NoteReady),
        .i_NoteOn(i_NoteOn), .i_NoteId(i_NoteId), .i_Frequency(i_Frequency),
        .o_RegisterNumber(o_RegisterNumber), .o_RegisterValue(o_RegisterValue),
        .o_RegisterWriteEnable(o_RegisterWriteEnable), .o_Dropped(o_Dropped),
        .o_ActiveVoices(o_ActiveVoices)
    );

    voice_allocator #(.NUM_VOICES(2), .AGE_W(4), .OP2_SHIFT(1)) u_dut2 (
        .i_Clock(i_Clock), .i_Reset(i_Reset),
        .i_NoteValid(i2_NoteValid), .o_NoteReady(o2_NoteReady),
        .i_NoteOn(i2_NoteOn), .i_NoteId(i2_NoteId), .i_Frequency(i2_Frequency),
        .o_RegisterNumber(o2_RegisterNumber), .o_RegisterValue(o2_RegisterValue),
        .o_RegisterWriteEnable(o2_RegisterWriteEnable), .o_Dropped(o2_Dropped),
        .o_ActiveVoices(o2_ActiveVoices)
    );

    always #5 i_Clock = ~i_Clock;

    always @(posedge i_Clock) cyc <= cyc + 1;

    // Monitor for the main instance
    always @(negedge i_Clock) begin
        if (o_RegisterWriteEnable === 1'b1 || o_Dropped === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL dut1_unexpected cyc=%0d we=%0b drop=%0b num=%h val=%h",
                         cyc, o_RegisterWriteEnable, o_Dropped, o_RegisterNumber, o_RegisterValue);
            end else begin
                m1 = q1.pop_front();
                if ((m1.is_drop != o_Dropped) || (m1.cyc != cyc) ||
                    (!m1.is_drop && ((o_RegisterNumber != m1.num) || (o_RegisterValue != m1.val)))) begin
                    errors++;
                    $display("FAIL dut1_output got cyc=%0d drop=%0b num=%h val=%h want cyc=%0d drop=%0b num=%h val=%h",
                             cyc, o_Dropped, o_RegisterNumber, o_RegisterValue,
                             m1.cyc, m1.is_drop, m1.num, m1.val);
                end
            end
        end
    end

    // Monitor for the OP2_SHIFT=1 instance
    always @(negedge i_Clock) begin
        if (o2_RegisterWriteEnable === 1'b1 || o2_Dropped === 1'b1) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL dut2_unexpected cyc=%0d we=%0b drop=%0b num=%h val=%h",
                         cyc, o2_RegisterWriteEnable, o2_Dropped, o2_RegisterNumber, o2_RegisterValue);
            end else begin
                m2 = q2.pop_front();
                if ((m2.is_drop != o2_Dropped) || (m2.cyc != cyc) ||
                    (!m2.is_drop && ((o2_RegisterNumber != m2.num) || (o2_RegisterValue != m2.val)))) begin
                    errors++;
                    $display("FAIL dut2_output got cyc=%0d drop=%0b num=%h val=%h want cyc=%0d drop=%0b num=%h val=%h",
                             cyc, o2_Dropped, o2_RegisterNumber, o2_RegisterValue,
                             m2.cyc, m2.is_drop, m2.num, m2.val);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic start1(input logic on, input logic [6:0] id, input logic [23:0] f);
        t1 = cyc;
        chk("ready_at_accept", 32'(o_NoteReady), 32'd1);
        i_NoteValid = 1'b1;
        i_NoteOn    = on;
        i_NoteId    = id;
        i_Frequency = f;
    endtask

    task automatic exp_wr(input int off, input logic [7:0] n, input logic [23:0] v);
        q1.push_back('{1'b0, n, v, t1 + off});
    endtask

    task automatic exp_drop(input int off);
        q1.push_back('{1'b1, 8'h00, 24'h0, t1 + off});
    endtask

    task automatic finish1(input string nm, input int rdy, input logic [1:0] act);
        int n;
        @(posedge i_Clock);
        @(negedge i_Clock);
        i_NoteValid = 1'b0;
        n = 0;
        while (!o_NoteReady && n < 40) begin
            @(negedge i_Clock);
            n++;
        end
        chk({nm, "_ready_latency"}, (o_NoteReady === 1'b1) ? 32'(cyc - t1) : 32'hDEAD, 32'(rdy));
        chk({nm, "_active"}, 32'(o_ActiveVoices), 32'(act));
    endtask

    task automatic send2(input logic [6:0] id, input logic [23:0] f);
        t2 = cyc;
        i2_NoteValid = 1'b1;
        i2_NoteOn    = 1'b1;
        i2_NoteId    = id;
        i2_Frequency = f;
        @(posedge i_Clock);
        @(negedge i_Clock);
        i2_NoteValid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d want=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_NoteValid  = 1'b0; i_NoteOn  = 1'b0; i_NoteId  = '0; i_Frequency  = '0;
        i2_NoteValid = 1'b0; i2_NoteOn = 1'b0; i2_NoteId = '0; i2_Frequency = '0;
        i_Reset = 1'b1;
        repeat (3) @(negedge i_Clock);
        i_Reset = 1'b0;
        @(negedge i_Clock);

        chk("rst_ready",   32'(o_NoteReady), 32'd1);
        chk("rst_we",      32'(o_RegisterWriteEnable), 32'd0);
        chk("rst_num",     32'(o_RegisterNumber), 32'd0);
        chk("rst_val",     32'(o_RegisterValue), 32'd0);
        chk("rst_drop",    32'(o_Dropped), 32'd0);
        chk("rst_active",  32'(o_ActiveVoices), 32'd0);

        // OP2_SHIFT=1 instance: Op2 gets the doubled frequency, truncated to 24 bits
        send2(7'd60, 24'h001000);
        q2.push_back('{1'b0, 8'h02, 24'h001000, t2 + 2});
        q2.push_back('{1'b0, 8'h04, 24'h002000, t2 + 3});
        q2.push_back('{1'b0, 8'h05, 24'h000001, t2 + 4});
        repeat (5) @(negedge i_Clock);
        chk("dut2_ready", 32'(o2_NoteReady), 32'd1);
        send2(7'd61, 24'h800001);
        q2.push_back('{1'b0, 8'h12, 24'h800001, t2 + 2});
        q2.push_back('{1'b0, 8'h14, 24'h000002, t2 + 3});
        q2.push_back('{1'b0, 8'h15, 24'h000001, t2 + 4});
        repeat (5) @(negedge i_Clock);
        chk("dut2_active", 32'(o2_ActiveVoices), 32'd3);

        // fresh note-on to voice 0
        start1(1'b1, 7'd60, 24'h001000);
        exp_wr(2, 8'h02, 24'h001000); exp_wr(3, 8'h04, 24'h001000); exp_wr(4, 8'h05, 24'h000001);
        finish1("on60", 5, 2'b01);

        // fresh note-on to voice 1
        start1(1'b1, 7'd64, 24'h001400);
        exp_wr(2, 8'h12, 24'h001400); exp_wr(3, 8'h14, 24'h001400); exp_wr(4, 8'h15, 24'h000001);
        finish1("on64", 5, 2'b11);

        // pool full: steal voice 0 (oldest) or drop
        start1(1'b1, 7'd67, 24'h001800);
`ifdef VOICE_ALLOC_STEAL_EN
        exp_wr(2, 8'h05, 24'h000000); exp_wr(3, 8'h02, 24'h001800);
        exp_wr(4, 8'h04, 24'h001800); exp_wr(5, 8'h05, 24'h000001);
        finish1("on67_steal", 6, 2'b11);
`else
        exp_drop(2);
        finish1("on67_drop", 2, 2'b11);
`endif

        // retrigger the note held by voice 0; voice 1 untouched
        start1(1'b1, V0_ID, 24'h002000);
        exp_wr(2, 8'h05, 24'h000000); exp_wr(3, 8'h02, 24'h002000);
        exp_wr(4, 8'h04, 24'h002000); exp_wr(5, 8'h05, 24'h000001);
        finish1("retrig", 6, 2'b11);

        // matched note-off frees voice 1
        start1(1'b0, 7'd64, 24'h0);
        exp_wr(2, 8'h15, 24'h000000);
        finish1("off64", 3, 2'b01);

        // unmatched note-off: no writes
        start1(1'b0, 7'd99, 24'h0);
        finish1("off99", 2, 2'b01);

        // lowest free voice is now voice 1
        start1(1'b1, 7'd72, 24'h003000);
        exp_wr(2, 8'h12, 24'h003000); exp_wr(3, 8'h14, 24'h003000); exp_wr(4, 8'h15, 24'h000001);
        finish1("on72", 5, 2'b11);

        start1(1'b0, V0_ID, 24'h0);
        exp_wr(2, 8'h05, 24'h000000);
        finish1("off_v0", 3, 2'b10);

        // reset during WR_FREQ2 aborts the sequence
        start1(1'b1, 7'd80, 24'h004000);
        exp_wr(2, 8'h02, 24'h004000); exp_wr(3, 8'h04, 24'h004000);
        @(posedge i_Clock);
        @(negedge i_Clock);
        i_NoteValid = 1'b0;
        @(negedge i_Clock);
        @(negedge i_Clock);
        i_Reset = 1'b1;
        @(negedge i_Clock);
        i_Reset = 1'b0;
        @(negedge i_Clock);
        chk("midrst_ready",  32'(o_NoteReady), 32'd1);
        chk("midrst_active", 32'(o_ActiveVoices), 32'd0);
        chk("midrst_we",     32'(o_RegisterWriteEnable), 32'd0);
        chk("midrst_dut2_active", 32'(o2_ActiveVoices), 32'd0);
        repeat (10) @(negedge i_Clock);

        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
